// File: rtl/mips_alu_pkg.sv
// Shared definitions for the Mini-MIPS ALU path: control codes seen by both the
// ALU control decoder and the execute stage, plus the execute-stage FSM state.
package mips_alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MUL  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_MULT = 4'b1100;

    localparam int MUL_CNT_W = 6;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } alu_state_t;

    // Two's-complement magnitude; 0x8000_0000 maps to itself, read as unsigned 2^31.
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

    function automatic logic is_mul_code(input logic [3:0] code);
        return (code == ALU_MUL) || (code == ALU_MULT);
    endfunction

endpackage

// File: rtl/mips_mult_seq.sv
// Iterative shift-add multiplier on unsigned magnitudes with a final sign fix-up.
// done and product are combinational on the last iteration so the caller can
// register them on the same edge the iteration completes.
module mips_mult_seq
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    input  logic                 neg,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic                   busy;
    logic                   neg_q;
    logic [MUL_CNT_W-1:0]   count;
    logic [2*WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]     acc;
    logic [2*WIDTH-1:0]     acc_next;
    logic [WIDTH-1:0]       mplier;

    // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
        done     = busy && (count == MUL_CNT_W'(WIDTH - 1));
        product  = neg_q ? -acc_next : acc_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, so an aborted multiply leaves no stale state behind.
            busy   <= 1'b0;
            neg_q  <= 1'b0;
            count  <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            neg_q  <= neg;
            count  <= '0;
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            acc    <= '0;
            mplier <= b_mag;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + MUL_CNT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mips_alu_exec.sv
// Execute-stage ALU: valid/ready accept, single-cycle ops registered one cycle
// later, MUL/MULT handed to the sequential multiplier while the handshake is held busy.
module mips_alu_exec
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic [3:0]         alu_ctrl,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [4:0]         shamt,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               ovf,
    output logic               result_valid,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    alu_state_t             state;
    alu_state_t             state_next;
    logic                   accept;
    logic                   start_mul;
    logic                   is_mult_q;
    logic                   mult_done;
    logic [2*WIDTH-1:0]     product;
    logic [WIDTH-1:0]       sum;
    logic [WIDTH-1:0]       diff;
    logic [WIDTH-1:0]       alu_res;
    logic                   alu_ovf;

    assign ready_out = (state == ST_IDLE);
    assign accept    = valid_in && ready_out;
    assign start_mul = accept && is_mul_code(alu_ctrl);

    mips_mult_seq #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (start_mul),
        .a_mag   (magnitude(a)),
        .b_mag   (magnitude(b)),
        .neg     (a[WIDTH-1] ^ b[WIDTH-1]),
        .done    (mult_done),
        .product (product)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_mul) state_next = ST_MUL;
            ST_MUL:  if (mult_done) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sum     = a + b;
        diff    = a - b;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_ctrl)
            ALU_AND: alu_res = a & b;
            ALU_OR:  alu_res = a | b;
            ALU_XOR: alu_res = a ^ b;
            ALU_NOR: alu_res = ~(a | b);
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL: alu_res = b << shamt;
            ALU_SRL: alu_res = b >> shamt;
            ALU_SRA: alu_res = $unsigned($signed(b) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result       <= '0;
            zero         <= 1'b1;
            ovf          <= 1'b0;
            result_valid <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            is_mult_q    <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (state == ST_IDLE && accept) begin
                if (start_mul) begin
                    is_mult_q <= (alu_ctrl == ALU_MULT);
                end else begin
                    result       <= alu_res;
                    zero         <= (alu_res == '0);
                    ovf          <= alu_ovf;
                    result_valid <= 1'b1;
                end
            end else if (state == ST_MUL && mult_done) begin
                result       <= product[WIDTH-1:0];
                zero         <= (product[WIDTH-1:0] == '0);
                ovf          <= 1'b0;
                result_valid <= 1'b1;
                if (is_mult_q) begin
                    hi <= product[2*WIDTH-1:WIDTH];
                    lo <= product[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_alu_exec.sv
// Directed bench for mips_alu_exec: reset, single-cycle ops back to back,
// MUL/MULT latency and results, reset abort of a multiply, undefined codes.
module tb_mips_alu_exec;
    import mips_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic [3:0]  alu_ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mips_alu_exec #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .alu_ctrl     (alu_ctrl),
        .a            (a),
        .b            (b),
        .shamt        (shamt),
        .result       (result),
        .zero         (zero),
        .ovf          (ovf),
        .result_valid (result_valid),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  code;
        logic [31:0] va;
        logic [31:0] vb;
        logic [4:0]  sh;
        logic [31:0] exp_res;
        logic        exp_ovf;
    } vec_t;

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b1; alu_ctrl = ALU_ADD; a = 32'd1; b = 32'd2; shamt = '0;
        tick();
        tick();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_prio_valid: got %b want 0", result_valid); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_prio_result: got %h want 0", result); end
        rst = 1'b0; valid_in = 1'b0;
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ready_out); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL rst_zero: got %b want 1", zero); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rst_hilo: got %h_%h want 0_0", hi, lo); end
        tick();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", result_valid); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", ready_out); end
    endtask

    task automatic test_back_to_back();
        vec_t v[12];
        v[0]  = '{ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b1};
        v[1]  = '{ALU_SUB, 32'd5,         32'd5,         5'd0, 32'h0000_0000, 1'b0};
        v[2]  = '{ALU_SLT, 32'hFFFF_FFFF, 32'd1,         5'd0, 32'h0000_0001, 1'b0};
        v[3]  = '{ALU_SRA, 32'h1234_5678, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0};
        v[4]  = '{ALU_SRL, 32'h0,         32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0};
        v[5]  = '{ALU_SLL, 32'h0,         32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0};
        v[6]  = '{ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200, 1'b0};
        v[7]  = '{ALU_OR,  32'hF000_0001, 32'h0F00_0010, 5'd0, 32'hFF00_0011, 1'b0};
        v[8]  = '{ALU_XOR, 32'hFFFF_0000, 32'hF0F0_F0F0, 5'd0, 32'h0F0F_F0F0, 1'b0};
        v[9]  = '{ALU_NOR, 32'hFFFF_0000, 32'h0000_00FF, 5'd0, 32'h0000_FF00, 1'b0};
        v[10] = '{ALU_SUB, 32'h8000_0000, 32'd1,         5'd0, 32'h7FFF_FFFF, 1'b1};
        v[11] = '{ALU_SLT, 32'd1,         32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b0};
        for (int i = 0; i < 12; i++) begin
            valid_in = 1'b1; alu_ctrl = v[i].code; a = v[i].va; b = v[i].vb; shamt = v[i].sh;
            checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, ready_out); end
            tick();
            checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, result_valid); end
            checks++; if (result !== v[i].exp_res) begin errors++; $display("FAIL b2b_result[%0d]: got %h want %h", i, result, v[i].exp_res); end
            checks++; if (ovf !== v[i].exp_ovf) begin errors++; $display("FAIL b2b_ovf[%0d]: got %b want %b", i, ovf, v[i].exp_ovf); end
            checks++; if (zero !== (v[i].exp_res == 32'd0)) begin errors++; $display("FAIL b2b_zero[%0d]: got %b want %b", i, zero, v[i].exp_res == 32'd0); end
        end
        valid_in = 1'b0;
        tick();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse_end: got %b want 0", result_valid); end
        checks++; if (result !== 32'd0 || zero !== 1'b1) begin errors++; $display("FAIL b2b_hold: got %h/%b want 0/1", result, zero); end
    endtask

    task automatic run_mul(input string name, input logic [3:0] code, input logic [31:0] ra, input logic [31:0] rb,
                           input logic [31:0] exp_res, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat = 0;
        valid_in = 1'b1; alu_ctrl = code; a = ra; b = rb; shamt = '0;
        tick();
        // Keep offering a different op through the busy window; it must be ignored.
        alu_ctrl = ALU_ADD; a = 32'd100; b = 32'd23;
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL %s_busy_start: got %b want 0", name, ready_out); end
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (result_valid === 1'b1) begin
                lat = i;
                break;
            end
            checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL %s_busy[%0d]: got %b want 0", name, i, ready_out); end
        end
        valid_in = 1'b0;
        checks++; if (lat !== 32) begin errors++; $display("FAIL %s_latency: got %0d want 32", name, lat); end
        checks++; if (result !== exp_res) begin errors++; $display("FAIL %s_result: got %h want %h", name, result, exp_res); end
        checks++; if (zero !== (exp_res == 32'd0)) begin errors++; $display("FAIL %s_zero: got %b want %b", name, zero, exp_res == 32'd0); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL %s_ovf: got %b want 0", name, ovf); end
        checks++; if (hi !== exp_hi || lo !== exp_lo) begin errors++; $display("FAIL %s_hilo: got %h_%h want %h_%h", name, hi, lo, exp_hi, exp_lo); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL %s_ready_after: got %b want 1", name, ready_out); end
        tick();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL %s_pulse_end: got %b want 0", name, result_valid); end
        checks++; if (hi !== exp_hi || lo !== exp_lo || result !== exp_res) begin
            errors++; $display("FAIL %s_hold: got %h_%h/%h want %h_%h/%h", name, hi, lo, result, exp_hi, exp_lo, exp_res);
        end
    endtask

    task automatic test_mult();
        run_mul("mult_neg3x7", ALU_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_mul("mult_min_sq", ALU_MULT, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 32'h0000_0000);
        run_mul("mul_6x7", ALU_MUL, 32'd6, 32'd7, 32'd42, 32'h4000_0000, 32'h0000_0000);
        run_mul("mul_neg2x5", ALU_MUL, 32'hFFFF_FFFE, 32'd5, 32'hFFFF_FFF6, 32'h4000_0000, 32'h0000_0000);
        run_mul("mult_big", ALU_MULT, 32'h0001_0001, 32'hFFFF_FFFF, 32'hFFFE_FFFF, 32'hFFFF_FFFF, 32'hFFFE_FFFF);
    endtask

    task automatic test_reset_during_mult();
        int spurious = 0;
        valid_in = 1'b1; alu_ctrl = ALU_MULT; a = 32'd3; b = 32'd5; shamt = '0;
        tick();
        valid_in = 1'b0;
        for (int i = 1; i <= 9; i++) tick();
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", ready_out); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", ready_out); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL abort_hilo: got %h_%h want 0_0", hi, lo); end
        checks++; if (result !== 32'd0 || zero !== 1'b1 || result_valid !== 1'b0) begin
            errors++; $display("FAIL abort_outputs: got %h/%b/%b want 0/1/0", result, zero, result_valid);
        end
        valid_in = 1'b1; alu_ctrl = ALU_ADD; a = 32'd2; b = 32'd3;
        tick();
        valid_in = 1'b0;
        checks++; if (result_valid !== 1'b1 || result !== 32'd5) begin
            errors++; $display("FAIL abort_add: got %b/%h want 1/00000005", result_valid, result);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (result_valid !== 1'b0) spurious++;
        end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL abort_no_late_done: got %0d pulses want 0", spurious); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL abort_hilo_late: got %h_%h want 0_0", hi, lo); end
    endtask

    task automatic test_undefined();
        logic [3:0] codes [3];
        codes[0] = 4'b1111; codes[1] = 4'b1011; codes[2] = 4'b1101;
        valid_in = 1'b1; alu_ctrl = ALU_ADD; a = 32'h7FFF_FFFF; b = 32'd1;
        tick();
        for (int i = 0; i < 3; i++) begin
            alu_ctrl = codes[i]; a = 32'h1234_5678; b = 32'h0000_00FF; shamt = 5'd3;
            tick();
            checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL undef_valid[%b]: got %b want 1", codes[i], result_valid); end
            checks++; if (result !== 32'd0 || zero !== 1'b1 || ovf !== 1'b0) begin
                errors++; $display("FAIL undef_out[%b]: got %h/%b/%b want 0/1/0", codes[i], result, zero, ovf);
            end
        end
        valid_in = 1'b0;
        tick();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL undef_pulse_end: got %b want 0", result_valid); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mult();
        test_reset_during_mult();
        test_undefined();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
